uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 34 +++
 rtl/uart_rx.sv | 137 +++++++++++++
 tb/tb_uart_rx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants and state encoding shared by the UART receiver and
// transmitter.
//   uart_state_e           frame state encoding (IDLE/START/DATA/STOP)
//   UART_DATA_BITS         data bits per frame (8N1 framing)
//   BAUD_CNT_W             width of the per-bit cycle counter
//   BAUND_EN_INTERVAL_DEF  default clock cycles per bit (simulation value)
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_DATA_BITS        = 8;
  localparam int BAUD_CNT_W            = 16;
  localparam int BAUND_EN_INTERVAL_DEF = 100;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: brings the asynchronous serial line into the clock domain and
// flags the 1->0 transition that marks a candidate start bit.
//   clk   in   system clock, rising edge
//   rst   in   synchronous reset, active-high (all flops reset to idle level 1)
//   rx    in   asynchronous serial line
//   rx_s  out  synchronised line level (2 cycles after rx)
//   fall  out  high for one cycle when rx_s goes from 1 to 0
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic rx_s1;
  logic rx_s_d;

  // Reset to the idle level so leaving reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1  <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_s1  <= rx;
      rx_s   <= rx_s1;
      rx_s_d <= rx_s;
    end
  end

  assign fall = rx_s_d & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. Detects the start edge, confirms the start bit
// at mid-bit, samples 8 data bits LSB first at mid-bit and checks the stop bit.
//   Clk            in   system clock, rising edge
//   Rst            in   synchronous reset, active-high; aborts any frame
//   In_rx          in   asynchronous serial line, idle high
//   Out_data       out  last correctly received byte (held until next good frame)
//   Out_data_vld   out  one-cycle pulse: Out_data holds a new byte
//   Out_frame_err  out  one-cycle pulse: stop bit sampled as 0
//   Out_busy       out  high whenever the FSM is not in IDLE
// Handshake: Out_data_vld is a pulse with no ready; a consumer that misses it
// loses the byte. Out_data_vld and Out_frame_err never assert together.
// Internal debug: 'state' holds the FSM state, 'sample' marks every bit sample.
module uart_rx
  import uart_pkg::*;
#(
  parameter int TCQ               = 1,
  parameter int CLK_FREQ          = 100000000,
  parameter int BAUND_RATE        = 9600,
  parameter int BAUND_EN_INTERVAL = BAUND_EN_INTERVAL_DEF
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       In_rx,
  output logic [7:0] Out_data,
  output logic       Out_data_vld,
  output logic       Out_frame_err,
  output logic       Out_busy
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_START = START;
  localparam logic [1:0] S_DATA  = DATA;
  localparam logic [1:0] S_STOP  = STOP;

  localparam int BIT_CNT_W = $clog2(UART_DATA_BITS);

  // Start bit is confirmed half a bit after the edge; every later sample is a
  // full bit apart, which keeps all samples near mid-bit.
  localparam logic [BAUD_CNT_W-1:0] HALF_M1 = BAUD_CNT_W'((BAUND_EN_INTERVAL >> 1) - 1);
  localparam logic [BAUD_CNT_W-1:0] FULL_M1 = BAUD_CNT_W'(BAUND_EN_INTERVAL - 1);
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT = BIT_CNT_W'(UART_DATA_BITS - 1);

  // Clock and baud figures are informational; the bit interval is what counts.
  logic unused_cfg;
  assign unused_cfg = (TCQ != 0) ^ (CLK_FREQ != 0) ^ (BAUND_RATE != 0);

  logic                      rx_s;
  logic                      fall;
  logic [1:0]                state;
  logic [1:0]                state_nxt;
  logic [BAUD_CNT_W-1:0]     cnt;
  logic [BIT_CNT_W-1:0]      bit_cnt;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      sample;

  uart_rx_sync u_sync (
    .clk  (Clk),
    .rst  (Rst),
    .rx   (In_rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  always_comb begin
    sample = 1'b0;
    case (state)
      S_START: sample = (cnt == HALF_M1);
      S_DATA,
      S_STOP:  sample = (cnt == FULL_M1);
      default: sample = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (fall) state_nxt = S_START;
      // A high level at mid-start-bit was only a glitch.
      S_START: if (sample) state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (sample && (bit_cnt == LAST_BIT)) state_nxt = S_STOP;
      // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
      S_STOP:  if (sample) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counter restarts on every state entry and after each data sample, so the
  // next sample lands exactly one bit later.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt <= '0;
    end else if ((state_nxt != state) || sample) begin
      cnt <= '0;
    end else if (state != S_IDLE) begin
      cnt <= cnt + BAUD_CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (state == S_START) begin
        bit_cnt <= '0;
      end else if ((state == S_DATA) && sample) begin
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Out_data      <= 8'h00;
      Out_data_vld  <= 1'b0;
      Out_frame_err <= 1'b0;
    end else begin
      Out_data_vld  <= (state == S_STOP) && sample && rx_s;
      Out_frame_err <= (state == S_STOP) && sample && !rx_s;
      if ((state == S_STOP) && sample && rx_s) begin
        Out_data <= shreg;
      end
    end
  end

  assign Out_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a bit-interval of 100 cycles.
// Frames are driven by a bit-level transmitter task; a monitor scores every
// received byte against an expected queue.
module tb_uart_rx;

  localparam int I = 100;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       In_rx;
  logic [7:0] Out_data;
  logic       Out_data_vld;
  logic       Out_frame_err;
  logic       Out_busy;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  int vld_cnt = 0;
  int err_cnt = 0;
  int vld_cyc = 0;
  int err_cyc = 0;
  logic busy_post = 1'b1;
  logic prev_vld  = 1'b0;
  logic prev_pulse = 1'b0;
  logic samp_en   = 1'b0;
  logic [7:0] exp_q[$];
  int samp_q[$];

  uart_rx #(.BAUND_EN_INTERVAL(I)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .In_rx         (In_rx),
    .Out_data      (Out_data),
    .Out_data_vld  (Out_data_vld),
    .Out_frame_err (Out_frame_err),
    .Out_busy      (Out_busy)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge Clk) begin
    if (prev_vld) busy_post = Out_busy;
    if (samp_en && dut.sample) samp_q.push_back(cyc);
    if (Out_data_vld === 1'b1 || Out_frame_err === 1'b1) begin
      check("pulse_exclusive", {31'b0, Out_data_vld & Out_frame_err}, 32'd0);
      check("pulse_gap", {31'b0, prev_pulse}, 32'd0);
    end
    if (Out_data_vld === 1'b1) begin
      vld_cnt++;
      vld_cyc = cyc;
      if (exp_q.size() == 0) check("unexpected_vld", 32'd1, 32'd0);
      else check("rx_data", {24'b0, Out_data}, {24'b0, exp_q.pop_front()});
    end
    if (Out_frame_err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    prev_vld   = (Out_data_vld === 1'b1);
    prev_pulse = (Out_data_vld === 1'b1) || (Out_frame_err === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Drives start, 8 data bits LSB first, then the given stop level, I cycles
  // each. d returns the cycle at which the start edge was driven.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int d);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    d = cyc;
    for (int i = 0; i < 10; i++) begin
      In_rx = f[i];
      repeat (I) @(negedge Clk);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge Clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d;
    int d2;
    int base_v;
    int base_e;
    logic [9:0] f;

    Rst   = 1'b1;
    In_rx = 1'b1;
    idle(5);
    check("reset_data", {24'b0, Out_data}, 32'h00);
    check("reset_vld", {31'b0, Out_data_vld}, 32'd0);
    check("reset_err", {31'b0, Out_frame_err}, 32'd0);
    check("reset_busy", {31'b0, Out_busy}, 32'd0);
    Rst = 1'b0;
    idle(20);

    // Loopback byte A5.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, d);
    idle(I);
    check("a5_vld_cnt", vld_cnt, 32'd1);
    check("a5_err_cnt", err_cnt, 32'd0);
    check("a5_data", {24'b0, Out_data}, 32'hA5);
    check("a5_vld_time", vld_cyc, d + 953);
    check("a5_busy_after", {31'b0, busy_post}, 32'd0);

    // Back-to-back 00 then FF with no idle gap.
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, d);
    send_frame(8'hFF, 1'b1, d2);
    idle(I);
    check("b2b_vld_cnt", vld_cnt, 32'd3);
    check("b2b_second_time", vld_cyc, d2 + 953);
    check("b2b_last_data", {24'b0, Out_data}, 32'hFF);
    check("b2b_queue_empty", exp_q.size(), 32'd0);

    // Sample timing on 81.
    exp_q.push_back(8'h81);
    samp_q.delete();
    samp_en = 1'b1;
    send_frame(8'h81, 1'b1, d);
    idle(I);
    samp_en = 1'b0;
    check("t81_sample_count", samp_q.size(), 32'd10);
    for (int k = 0; k < 10 && k < samp_q.size(); k++) begin
      int diff;
      diff = samp_q[k] - (d + 2 + I / 2 + k * I);
      check($sformatf("t81_sample_%0d", k), {31'b0, (diff >= -1 && diff <= 1)}, 32'd1);
    end
    check("t81_vld_time", vld_cyc, d + 953);
    check("t81_data", {24'b0, Out_data}, 32'h81);

    // Glitch: 20 cycles low.
    base_v = vld_cnt;
    base_e = err_cnt;
    d = cyc;
    In_rx = 1'b0;
    idle(20);
    In_rx = 1'b1;
    wait_until(d + 12);
    check("glitch_busy_mid", {31'b0, Out_busy}, 32'd1);
    wait_until(d + 54);
    check("glitch_busy_end", {31'b0, Out_busy}, 32'd0);
    idle(2 * I);
    check("glitch_no_vld", vld_cnt, base_v);
    check("glitch_no_err", err_cnt, base_e);

    // Frame error: 3C with stop bit 0, then break for 3 bit times.
    send_frame(8'h3C, 1'b0, d);
    idle(3 * I);
    check("ferr_err_cnt", err_cnt, base_e + 1);
    check("ferr_err_time", err_cyc, d + 953);
    check("ferr_no_vld", vld_cnt, base_v);
    check("ferr_data_held", {24'b0, Out_data}, 32'h81);
    check("ferr_break_idle", {31'b0, Out_busy}, 32'd0);
    In_rx = 1'b1;
    idle(I);
    check("ferr_no_rearm", err_cnt, base_e + 1);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, d);
    idle(I);
    check("ferr_recover_vld", vld_cnt, base_v + 1);
    check("ferr_recover_data", {24'b0, Out_data}, 32'h96);

    // Reset during data bit 4 of 5A.
    base_v = vld_cnt;
    base_e = err_cnt;
    f = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 5; i++) begin
      In_rx = f[i];
      idle(I);
    end
    In_rx = f[5];
    idle(I / 2);
    check("rst_busy_before", {31'b0, Out_busy}, 32'd1);
    Rst = 1'b1;
    idle(1);
    Rst = 1'b0;
    check("rst_busy_after", {31'b0, Out_busy}, 32'd0);
    check("rst_data_cleared", {24'b0, Out_data}, 32'h00);
    In_rx = 1'b1;
    idle(10 * I);
    check("rst_no_vld", vld_cnt, base_v);
    check("rst_no_err", err_cnt, base_e);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, d);
    idle(I);
    check("rst_c3_vld", vld_cnt, base_v + 1);
    check("rst_c3_data", {24'b0, Out_data}, 32'hC3);
    check("rst_c3_time", vld_cyc, d + 953);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
